sig_gen_ctrl: RTL and testbench

Front-panel controller for the signal generator. It debounces three active-low push keys and lets the user pick a waveform field and step its value. It holds the four 2-bit settings `cnt_sig`, `cnt_amp`, `cnt_fre` and `cnt_phase`, and sequences the `confirm` run/stop strobe. It sits between the board keys and the generator datapath, and also exports the edit state for a display block.

---
 rtl/sig_gen_ctrl_pkg.sv | 40 ++++
 rtl/key_debounce.sv | 76 +++++++
 rtl/sig_gen_ctrl.sv | 120 ++++++++++++
 tb/tb_sig_gen_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sig_gen_ctrl_pkg.sv
// Shared types and constants for the signal-generator front-panel controller.
// Build option SIG_GEN_CTRL_DEBOUNCE_EN selects the counter debouncer in key_debounce.
package sig_gen_ctrl_pkg;

    typedef enum logic [2:0] {
        EDIT_SIG   = 3'd0,
        EDIT_AMP   = 3'd1,
        EDIT_FRE   = 3'd2,
        EDIT_PHASE = 3'd3,
        START      = 3'd4,
        RUN        = 3'd5
    } ctrl_state_e;

    localparam logic [1:0] FIELD_SIG   = 2'd0;
    localparam logic [1:0] FIELD_AMP   = 2'd1;
    localparam logic [1:0] FIELD_FRE   = 2'd2;
    localparam logic [1:0] FIELD_PHASE = 2'd3;

    localparam logic [1:0] SIG_RST   = 2'd0;
    localparam logic [1:0] AMP_RST   = 2'd0;
    localparam logic [1:0] FRE_RST   = 2'd0;
    localparam logic [1:0] PHASE_RST = 2'd0;

    function automatic logic [1:0] next_field(input logic [1:0] field);
        return field + 2'd1;
    endfunction

    function automatic ctrl_state_e edit_state(input logic [1:0] field);
        ctrl_state_e st;
        case (field)
            FIELD_SIG:   st = EDIT_SIG;
            FIELD_AMP:   st = EDIT_AMP;
            FIELD_FRE:   st = EDIT_FRE;
            FIELD_PHASE: st = EDIT_PHASE;
            default:     st = EDIT_SIG;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low key conditioner: 2-FF synchronizer, optional counter debouncer
// (SIG_GEN_CTRL_DEBOUNCE_EN) and a single-cycle registered press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    logic       sync1_r;
    logic       sync2_r;
    logic [1:0] fill_r;
    logic       level_s;
    logic       level_d_r;
    logic       press_r;

    // Synchronizer plus a fill marker: sync2_r carries a real sample once fill_r[1] is set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            fill_r  <= 2'b00;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
            fill_r  <= {fill_r[0], 1'b1};
        end
    end

`ifdef SIG_GEN_CTRL_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             level_r;

    // Accepted level starts "pressed" so a key held through reset never yields a press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
        end else if (fill_r[1] && (sync2_r != level_r)) begin
            if (cnt_r == CNT_MAX) begin
                cnt_r   <= '0;
                level_r <= sync2_r;
            end else begin
                cnt_r   <= cnt_r + CNT_W'(1);
                level_r <= level_r;
            end
        end else begin
            cnt_r   <= '0;
            level_r <= level_r;
        end
    end

    assign level_s = level_r;
`else
    assign level_s = fill_r[1] ? sync2_r : 1'b0;
`endif

    // Falling-edge detect on the accepted level, registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_d_r <= 1'b0;
            press_r   <= 1'b0;
        end else begin
            level_d_r <= level_s;
            press_r   <= level_d_r & ~level_s;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/sig_gen_ctrl.sv
// Front-panel controller: three conditioned keys drive the edit/run FSM and the
// four 2-bit generator settings. Build option: SIG_GEN_CTRL_DEBOUNCE_EN.
module sig_gen_ctrl
    import sig_gen_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_ok,
    output logic [1:0] cnt_sig,
    output logic [1:0] cnt_amp,
    output logic [1:0] cnt_fre,
    output logic [1:0] cnt_phase,
    output logic       confirm,
    output logic [1:0] cur_field,
    output logic       running
);

    logic        mode_ev_s;
    logic        inc_ev_s;
    logic        ok_ev_s;
    ctrl_state_e state_r;
    logic [1:0]  cnt_sig_r;
    logic [1:0]  cnt_amp_r;
    logic [1:0]  cnt_fre_r;
    logic [1:0]  cnt_phase_r;
    logic        confirm_r;
    logic        running_r;
    logic [1:0]  cur_field_r;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
        .clk   (clk_50M),
        .rst_n (rst_n),
        .key_n (key_mode),
        .press (mode_ev_s)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
        .clk   (clk_50M),
        .rst_n (rst_n),
        .key_n (key_inc),
        .press (inc_ev_s)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_ok (
        .clk   (clk_50M),
        .rst_n (rst_n),
        .key_n (key_ok),
        .press (ok_ev_s)
    );

    // Edit/run FSM with settings; ok beats mode beats inc, losers are dropped.
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state_r     <= EDIT_SIG;
            cnt_sig_r   <= SIG_RST;
            cnt_amp_r   <= AMP_RST;
            cnt_fre_r   <= FRE_RST;
            cnt_phase_r <= PHASE_RST;
            confirm_r   <= 1'b0;
            running_r   <= 1'b0;
            cur_field_r <= FIELD_SIG;
        end else begin
            case (state_r)
                EDIT_SIG, EDIT_AMP, EDIT_FRE, EDIT_PHASE: begin
                    if (ok_ev_s) begin
                        state_r <= START;
                    end else if (mode_ev_s) begin
                        state_r     <= edit_state(next_field(cur_field_r));
                        cur_field_r <= next_field(cur_field_r);
                    end else if (inc_ev_s) begin
                        case (cur_field_r)
                            FIELD_SIG:   cnt_sig_r   <= cnt_sig_r + 2'd1;
                            FIELD_AMP:   cnt_amp_r   <= cnt_amp_r + 2'd1;
                            FIELD_FRE:   cnt_fre_r   <= cnt_fre_r + 2'd1;
                            FIELD_PHASE: cnt_phase_r <= cnt_phase_r + 2'd1;
                            default:     cnt_sig_r   <= cnt_sig_r;
                        endcase
                    end else begin
                        state_r <= state_r;
                    end
                end
                // One guaranteed low cycle of confirm after any edit.
                START: begin
                    state_r   <= RUN;
                    confirm_r <= 1'b1;
                    running_r <= 1'b1;
                end
                RUN: begin
                    if (ok_ev_s) begin
                        state_r     <= EDIT_SIG;
                        cur_field_r <= FIELD_SIG;
                        confirm_r   <= 1'b0;
                        running_r   <= 1'b0;
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r     <= EDIT_SIG;
                    cur_field_r <= FIELD_SIG;
                    confirm_r   <= 1'b0;
                    running_r   <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_sig   = cnt_sig_r;
    assign cnt_amp   = cnt_amp_r;
    assign cnt_fre   = cnt_fre_r;
    assign cnt_phase = cnt_phase_r;
    assign confirm   = confirm_r;
    assign running   = running_r;
    assign cur_field = cur_field_r;

endmodule

// File: tb/tb_sig_gen_ctrl.sv
// Directed bench for sig_gen_ctrl with DEBOUNCE_CYCLES = 8; expectations follow
// whichever SIG_GEN_CTRL_DEBOUNCE_EN build is compiled.
module tb_sig_gen_ctrl;

    localparam int N      = 8;
`ifdef SIG_GEN_CTRL_DEBOUNCE_EN
    localparam int LAT    = N + 3;   // key edge to press pulse edge
    localparam bit FILTER = 1'b1;
`else
    localparam int LAT    = 3;
    localparam bit FILTER = 1'b0;
`endif
    localparam int HOLD   = 14;
    localparam int SETTLE = 30;

    logic       clk_50M = 1'b0;
    logic       rst_n;
    logic       key_mode;
    logic       key_inc;
    logic       key_ok;
    logic [1:0] cnt_sig;
    logic [1:0] cnt_amp;
    logic [1:0] cnt_fre;
    logic [1:0] cnt_phase;
    logic       confirm;
    logic [1:0] cur_field;
    logic       running;

    int n_cmp = 0;
    int n_err = 0;
    int exp_sig;

    sig_gen_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .key_ok    (key_ok),
        .cnt_sig   (cnt_sig),
        .cnt_amp   (cnt_amp),
        .cnt_fre   (cnt_fre),
        .cnt_phase (cnt_phase),
        .confirm   (confirm),
        .cur_field (cur_field),
        .running   (running)
    );

    always #5 clk_50M = ~clk_50M;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // keys_low: bit0 mode, bit1 inc, bit2 ok
    task automatic tap(input logic [2:0] keys_low, input int hold);
        @(posedge clk_50M);
        #1;
        key_mode = ~keys_low[0];
        key_inc  = ~keys_low[1];
        key_ok   = ~keys_low[2];
        repeat (hold) @(posedge clk_50M);
        #1;
        key_mode = 1'b1;
        key_inc  = 1'b1;
        key_ok   = 1'b1;
        repeat (SETTLE) @(posedge clk_50M);
        @(negedge clk_50M);
    endtask

    // Press ok and sample confirm every cycle; rise_edge/fall_edge mark the expected change.
    task automatic timed_ok(input bit rising);
        @(posedge clk_50M);
        #1;
        key_ok = 1'b0;
        for (int k = 1; k <= HOLD; k++) begin
            @(posedge clk_50M);
            @(negedge clk_50M);
            if (rising && k == LAT + 1) check("confirm_low_in_start", int'(confirm), 0);
            if (rising && k == LAT + 2) check("confirm_rise", int'(confirm), 1);
            if (!rising && k == LAT)     check("confirm_before_fall", int'(confirm), 1);
            if (!rising && k == LAT + 1) check("confirm_fall", int'(confirm), 0);
        end
        key_ok = 1'b1;
        repeat (SETTLE) @(posedge clk_50M);
        @(negedge clk_50M);
    endtask

    initial begin
        rst_n    = 1'b0;
        key_mode = 1'b1;
        key_inc  = 1'b1;
        key_ok   = 1'b1;
        repeat (3) @(posedge clk_50M);
        @(negedge clk_50M);
        check("rst_settings", int'({cnt_sig, cnt_amp, cnt_fre, cnt_phase}), 0);
        check("rst_confirm", int'(confirm), 0);
        check("rst_running", int'(running), 0);
        check("rst_field", int'(cur_field), 0);
        rst_n = 1'b1;
        repeat (SETTLE) @(posedge clk_50M);

        // inc x4 in EDIT_SIG wraps 1,2,3,0
        for (int i = 1; i <= 4; i++) begin
            tap(3'b010, 12);
            check($sformatf("sig_inc%0d", i), int'(cnt_sig), i % 4);
        end
        check("others_zero", int'({cnt_amp, cnt_fre, cnt_phase}), 0);

        tap(3'b001, 12);
        tap(3'b001, 12);
        check("field_fre", int'(cur_field), 2);
        for (int i = 0; i < 3; i++) tap(3'b010, 12);
        check("fre_val", int'(cnt_fre), 3);
        check("sig_untouched", int'(cnt_sig), 0);
        tap(3'b001, 12);
        tap(3'b001, 12);
        check("field_wrap", int'(cur_field), 0);
        tap(3'b001, 12);
        check("field_amp", int'(cur_field), 1);

        // start, ignore edits while running, stop
        timed_ok(1'b1);
        check("running_on", int'(running), 1);
        check("field_held_run", int'(cur_field), 1);
        tap(3'b010, 12);
        tap(3'b001, 12);
        check("run_frozen_amp", int'(cnt_amp), 0);
        check("run_frozen_field", int'(cur_field), 1);
        check("run_confirm_held", int'(confirm), 1);
        timed_ok(1'b0);
        check("stop_field", int'(cur_field), 0);
        check("stop_running", int'(running), 0);

        // glitch filtering on key_inc (EDIT_SIG, cnt_sig = 0)
        exp_sig = 0;
        for (int i = 0; i < 3; i++) begin
            tap(3'b010, 5);
            if (!FILTER) exp_sig = (exp_sig + 1) % 4;
        end
        check("glitch_sig", int'(cnt_sig), exp_sig);
        tap(3'b010, 12);
        exp_sig = (exp_sig + 1) % 4;
        check("press12_sig", int'(cnt_sig), exp_sig);
        tap(3'b010, 1000);
        exp_sig = (exp_sig + 1) % 4;
        check("hold1000_sig", int'(cnt_sig), exp_sig);

        // ok and inc together: ok wins, inc dropped
        tap(3'b001, 12);
        tap(3'b010, 12);
        tap(3'b010, 12);
        check("amp_two", int'(cnt_amp), 2);
        tap(3'b110, 12);
        check("ok_inc_running", int'(running), 1);
        check("ok_inc_amp", int'(cnt_amp), 2);
        check("ok_inc_field", int'(cur_field), 1);

        // reset mid-RUN with key_inc held through it
        @(posedge clk_50M);
        #1;
        key_inc = 1'b0;
        repeat (20) @(posedge clk_50M);
        #1;
        rst_n = 1'b0;
        @(posedge clk_50M);
        @(negedge clk_50M);
        check("midrun_rst_settings", int'({cnt_sig, cnt_amp, cnt_fre, cnt_phase}), 0);
        check("midrun_rst_confirm", int'(confirm), 0);
        check("midrun_rst_running", int'(running), 0);
        check("midrun_rst_field", int'(cur_field), 0);
        rst_n = 1'b1;
        repeat (40) @(posedge clk_50M);
        @(negedge clk_50M);
        check("held_no_event", int'(cnt_sig), 0);
        key_inc = 1'b1;
        repeat (SETTLE) @(posedge clk_50M);
        @(negedge clk_50M);
        check("release_no_event", int'(cnt_sig), 0);
        tap(3'b010, 12);
        check("repress_event", int'(cnt_sig), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
